voice_allocator: RTL

VOICE_ALLOCATOR -- requirements
Module: voice_allocator

---
 rtl/voice_allocator.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/voice_allocator.sv
// Four-voice note allocator: each command takes three cycles (latch, select a target voice, apply).
// Voice choice on note-on is retrigger, then a free voice, then steal the oldest (age 3).

module voice_slot #(
    parameter logic [1:0] RST_AGE = 2'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr,
    input  logic        age_inc,
    input  logic        gate_clr,
    input  logic [19:0] freq_in,
    input  logic [1:0]  wave_in,
    input  logic [6:0]  note_in,
    output logic [19:0] freq,
    output logic [1:0]  ctrl,
    output logic [6:0]  note,
    output logic        gate,
    output logic [1:0]  age,
    output logic        phase_rst
);
    always_ff @(posedge clk) begin
        if (reset) begin
            freq      <= '0;
            ctrl      <= '0;
            note      <= '0;
            gate      <= 1'b0;
            age       <= RST_AGE;
            phase_rst <= 1'b0;
        end else begin
            phase_rst <= wr;
            if (wr) begin
                freq <= freq_in;
                ctrl <= wave_in;
                note <= note_in;
                gate <= 1'b1;
                age  <= 2'd0;
            end else begin
                if (gate_clr) gate <= 1'b0;
                if (age_inc)  age  <= age + 2'd1;
            end
        end
    end
endmodule

module voice_allocator #(
    parameter int NUM_VOICES = 4   // only 4 is supported: indices and ages are 2 bits
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [1:0]                 cmd_type,
    input  logic [6:0]                 cmd_note,
    input  logic [19:0]                cmd_freq,
    input  logic [1:0]                 cmd_wave,
    output logic [NUM_VOICES*20-1:0]   voice_freq,
    output logic [NUM_VOICES*2-1:0]    voice_ctrl,
    output logic [NUM_VOICES-1:0]      voice_gate,
    output logic [NUM_VOICES-1:0]      voice_reset,
    output logic                       stolen,
    output logic                       miss
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SCAN  = 2'd1;
    localparam logic [1:0] ST_APPLY = 2'd2;

    localparam logic [1:0] CMD_ON  = 2'b00;
    localparam logic [1:0] CMD_OFF = 2'b01;
    localparam logic [1:0] CMD_ALL = 2'b10;

    logic [1:0]  state;
    logic [1:0]  type_q, wave_q;
    logic [6:0]  note_q;
    logic [19:0] freq_q;
    logic [1:0]  tgt_q;
    logic        hit_q, steal_q;

    logic [NUM_VOICES-1:0][6:0] vnote;
    logic [NUM_VOICES-1:0][1:0] age;
    logic [NUM_VOICES-1:0]      wr, age_inc, gate_clr;

    logic       m_hit, f_hit;
    logic [1:0] m_idx, f_idx, o_idx;

    assign cmd_ready = (state == ST_IDLE);

    // Descending loop so the lowest matching index wins.
    always_comb begin
        m_hit = 1'b0;
        m_idx = '0;
        f_hit = 1'b0;
        f_idx = '0;
        o_idx = '0;
        for (int v = NUM_VOICES - 1; v >= 0; v--) begin
            if (voice_gate[v] && vnote[v] == note_q) begin
                m_hit = 1'b1;
                m_idx = 2'(v);
            end
            if (!voice_gate[v]) begin
                f_hit = 1'b1;
                f_idx = 2'(v);
            end
            if (age[v] == 2'(NUM_VOICES - 1)) o_idx = 2'(v);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            type_q  <= '0;
            note_q  <= '0;
            freq_q  <= '0;
            wave_q  <= '0;
            tgt_q   <= '0;
            hit_q   <= 1'b0;
            steal_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (cmd_valid) begin
                    type_q <= cmd_type;
                    note_q <= cmd_note;
                    freq_q <= cmd_freq;
                    wave_q <= cmd_wave;
                    state  <= ST_SCAN;
                end
                ST_SCAN: begin
                    tgt_q   <= m_hit ? m_idx : (f_hit ? f_idx : o_idx);
                    hit_q   <= m_hit;
                    steal_q <= !m_hit && !f_hit;
                    state   <= ST_APPLY;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    logic is_on, is_off, is_all;
    assign is_on  = (state == ST_APPLY) && (type_q == CMD_ON);
    assign is_off = (state == ST_APPLY) && (type_q == CMD_OFF);
    assign is_all = (state == ST_APPLY) && (type_q == CMD_ALL);

    always_ff @(posedge clk) begin
        if (reset) begin
            stolen <= 1'b0;
            miss   <= 1'b0;
        end else begin
            stolen <= is_on && steal_q;
            miss   <= is_off && !hit_q;
        end
    end

    genvar v;
    generate
        for (v = 0; v < NUM_VOICES; v++) begin : g_voice
            // Everything newer than the target ages by one; the target becomes newest.
            assign wr[v]       = is_on && (tgt_q == 2'(v));
            assign age_inc[v]  = is_on && (age[v] < age[tgt_q]);
            assign gate_clr[v] = is_all || (is_off && hit_q && (tgt_q == 2'(v)));

            voice_slot #(.RST_AGE(2'(NUM_VOICES - 1 - v))) u_slot (
                .clk       (clk),
                .reset     (reset),
                .wr        (wr[v]),
                .age_inc   (age_inc[v]),
                .gate_clr  (gate_clr[v]),
                .freq_in   (freq_q),
                .wave_in   (wave_q),
                .note_in   (note_q),
                .freq      (voice_freq[20*v +: 20]),
                .ctrl      (voice_ctrl[2*v +: 2]),
                .note      (vnote[v]),
                .gate      (voice_gate[v]),
                .age       (age[v]),
                .phase_rst (voice_reset[v])
            );
        end
    endgenerate
endmodule
